ssi_scan_decoder: RTL and testbench
===================================

// Module: ssi_scan_decoder
// PURPOSE
//  Receive-side counterpart of the multiplexed 7-segment driver. Monitors the scanned digit-select and segment
//  lines and reconstructs the four displayed hex digits, with per-digit valid flags and a frame strobe.
//  Used for on-chip display self-check and for feeding displayed values back to test logic.
// PARAMETERS
//  STABLE_CYCLES   1024     cycles a (select,segments) pair must be unchanged before capture; >=2
//  TIMEOUT_CYCLES  4194304  cycles without any capture before all digits are invalidated; >STABLE_CYCLES
//  SEG_ACTIVE_LOW  1        1: segment lit when line is 0; 0: lit when line is 1
// PORTS
//  i_clk             in   1  clock
//  i_reset           in   1  reset, asynchronous, active-high
//  i_ssi_code        in   4  digit select, active-low; bit0=units .. bit3=thousands
//  i_segments        in   7  segment lines, bit order {g,f,e,d,c,b,a}
//  o_digit           out  4  decoded units digit
//  o_digit_ten       out  4  decoded tens digit
//  o_digit_hundred   out  4  decoded hundreds digit
//  o_digit_thousand  out  4  decoded thousands digit
//  o_valid           out  4  per-digit valid, bit n = digit n
//  o_frame_done      out  1  1-cycle pulse: digits 0,1,2,3 captured in order
//  o_err_pattern     out  1  1-cycle pulse: stable segment pattern not in decode table
//  o_timeout         out  1  level: no capture for TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: all digit outputs 0, o_valid 0, o_frame_done 0, o_err_pattern 0, o_timeout 0; all counters 0,
//    capture-done flag 0, expected index 0. Reset asserted mid-operation aborts everything identically.
//  - Inputs pass a 2-flop synchroniser (all 11 bits); logic below uses synchronised pair P.
//  - Select legal iff exactly one bit of P.code is 0. All-ones (blank) or multi-zero: stable counter held 0,
//    capture-done cleared, no capture, no error.
//  - Stable counter: if P differs from P of previous cycle -> counter 0, capture-done 0; else if legal and
//    counter < STABLE_CYCLES-1 -> +1. Width $clog2(STABLE_CYCLES); saturates, never wraps.
//  - Capture: cycle where legal, counter == STABLE_CYCLES-1 and capture-done 0; sets capture-done (one capture
//    per dwell). Outputs update on the next edge. Pin change to output update = STABLE_CYCLES+2 edges.
//  - Decode: segments normalised to active-high (inverted if SEG_ACTIVE_LOW), matched against hex table
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//    Match: digit[idx] <= value, o_valid[idx] <= 1. No match: digit[idx] and o_valid[idx] unchanged,
//    o_err_pattern pulses 1 cycle. All-dark pattern (00) counts as no match.
//  - Frame tracking (decoded captures only): idx == expected -> expected+1 (mod 4); idx == 3 with
//    expected == 3 -> o_frame_done pulse, expected 0. Mismatch -> expected = (idx==0) ? 1 : 0.
//    Error captures reset expected to 0.
//  - Timeout counter: cleared on any capture (match or error), else +1, saturating at TIMEOUT_CYCLES.
//    On reaching TIMEOUT_CYCLES: o_valid <= 0, o_timeout <= 1, digit values retained.
//    o_timeout clears on the edge of the next successful decode.
//  - Capture and timeout in same cycle: capture wins (counter cleared, no invalidation).
// TESTING  (bench: STABLE_CYCLES=4, TIMEOUT_CYCLES=64, SEG_ACTIVE_LOW=1)
//  1 code=1110, seg=7'h79 (inverted 06) held 10 cycles -> o_digit=1, o_valid=0001, one capture only, no pulses.
//  2 scan 1110/0x40(0),1101/0x24(2),1011/0x30(3),0111/0x19(4), 8 cycles each -> digits 0,2,3,4, o_valid=1111,
//    one o_frame_done pulse on thousands capture.
//  3 seg changed every 3 cycles on code 1110 -> no capture; then code=1100 held 20 cycles -> no capture, no error.
//  4 code=1101, seg=7'h7F (all dark) held 8 cycles -> one o_err_pattern pulse, o_digit_ten/o_valid[1] unchanged.
//  5 after test 2, inputs frozen with code=1111 for 70 cycles -> o_valid=0000, o_timeout=1, digits retained;
//    then valid capture of units -> o_timeout=0, o_valid=0001.
//  6 scan order 0,1,3,0,1,2,3 -> exactly one o_frame_done (on final 3); reset asserted mid-dwell -> all outputs 0.

Source files
------------

// File: rtl/ssi_scan_decoder.sv
// Receive-side decoder for a scanned 4-digit 7-segment display.
// Rebuilds the shown hex digits from the select and segment lines.
module ssi_scan_decoder #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 4194304,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_ssi_code,
  input  logic [6:0] i_segments,
  output logic [3:0] o_digit,
  output logic [3:0] o_digit_ten,
  output logic [3:0] o_digit_hundred,
  output logic [3:0] o_digit_thousand,
  output logic [3:0] o_valid,
  output logic       o_frame_done,
  output logic       o_err_pattern,
  output logic       o_timeout
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [10:0]      sync1;
  logic [10:0]      sync2;
  logic [3:0]       p_code;
  logic [6:0]       p_seg;
  logic [6:0]       seg_hi;
  logic             changed;
  logic             sel_ok;
  logic [1:0]       idx;
  logic             hit;
  logic [3:0]       val;
  logic             capture;
  logic [SW-1:0]    stb_cnt;
  logic             cap_done;
  logic [TW-1:0]    to_cnt;
  logic [1:0]       exp_idx;
  logic [3:0][3:0]  dig;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {i_ssi_code, i_segments};
      sync2 <= sync1;
    end
  end

  assign p_code = sync2[10:7];
  assign p_seg  = sync2[6:0];
  // sync1 is next cycle's pair, so the dwell count restarts as P changes
  assign changed = (sync1 != sync2);
  assign seg_hi  = (SEG_ACTIVE_LOW != 0) ? ~p_seg : p_seg;

  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    case (~p_code)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (seg_hi)
      7'h3F: val = 4'h0;
      7'h06: val = 4'h1;
      7'h5B: val = 4'h2;
      7'h4F: val = 4'h3;
      7'h66: val = 4'h4;
      7'h6D: val = 4'h5;
      7'h7D: val = 4'h6;
      7'h07: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h6F: val = 4'h9;
      7'h77: val = 4'hA;
      7'h7C: val = 4'hB;
      7'h39: val = 4'hC;
      7'h5E: val = 4'hD;
      7'h79: val = 4'hE;
      7'h71: val = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  assign capture = sel_ok && (stb_cnt == STB_MAX) && !cap_done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stb_cnt  <= '0;
      cap_done <= 1'b0;
    end else if (changed || !sel_ok) begin
      stb_cnt  <= '0;
      cap_done <= 1'b0;
    end else begin
      if (stb_cnt != STB_MAX)
        stb_cnt <= stb_cnt + 1'b1;
      if (capture)
        cap_done <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dig           <= '0;
      o_valid       <= '0;
      o_frame_done  <= 1'b0;
      o_err_pattern <= 1'b0;
      o_timeout     <= 1'b0;
      exp_idx       <= '0;
      to_cnt        <= '0;
    end else begin
      o_frame_done  <= 1'b0;
      o_err_pattern <= 1'b0;
      if (capture) begin
        to_cnt <= '0;
        if (hit) begin
          dig[idx]     <= val;
          o_valid[idx] <= 1'b1;
          o_timeout    <= 1'b0;
          if (idx == exp_idx) begin
            exp_idx <= exp_idx + 1'b1;
            if (idx == 2'd3)
              o_frame_done <= 1'b1;
          end else begin
            exp_idx <= (idx == 2'd0) ? 2'd1 : 2'd0;
          end
        end else begin
          o_err_pattern <= 1'b1;
          exp_idx       <= '0;
        end
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_LAST) begin
          o_valid   <= '0;
          o_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_digit          = dig[0];
  assign o_digit_ten      = dig[1];
  assign o_digit_hundred  = dig[2];
  assign o_digit_thousand = dig[3];

endmodule

// File: tb/tb_ssi_scan_decoder.sv
// Directed bench for ssi_scan_decoder.
// Small dwell/timeout values keep the run short.
module tb_ssi_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code;
  logic [6:0] seg;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] valid;
  logic       frame, err, tmo;

  int n_chk  = 0;
  int n_fail = 0;
  int n_frm  = 0;
  int n_err  = 0;
  int f0, e0;

  ssi_scan_decoder #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_ssi_code      (code),
    .i_segments      (seg),
    .o_digit         (d0),
    .o_digit_ten     (d1),
    .o_digit_hundred (d2),
    .o_digit_thousand(d3),
    .o_valid         (valid),
    .o_frame_done    (frame),
    .o_err_pattern   (err),
    .o_timeout       (tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame) n_frm++;
    if (err)   n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [6:0] s,
                       input int n);
    code = c;
    seg  = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    code = 4'hF;
    seg  = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_out", {d3, d2, d1, d0, valid, frame, err, tmo}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single units digit
    f0 = n_frm; e0 = n_err;
    drive(4'b1110, 7'h79, 10);
    chk("t1_digit", d0, 4'h1);
    chk("t1_valid", valid, 4'b0001);
    chk("t1_pulses", (n_frm - f0) + (n_err - e0), 0);

    // 2: full scan 0,2,3,4
    f0 = n_frm;
    drive(4'b1110, 7'h40, 8);
    drive(4'b1101, 7'h24, 8);
    drive(4'b1011, 7'h30, 8);
    drive(4'b0111, 7'h19, 8);
    chk("t2_digits", {d3, d2, d1, d0}, 16'h4320);
    chk("t2_valid", valid, 4'b1111);
    chk("t2_frame", n_frm - f0, 1);
    chk("t2_tmo", tmo, 1'b0);

    // 5: blank display until timeout, then recapture
    drive(4'b1111, 7'h7F, 70);
    chk("t5_valid", valid, 4'b0000);
    chk("t5_tmo", tmo, 1'b1);
    chk("t5_keep", {d3, d2, d1, d0}, 16'h4320);
    drive(4'b1110, 7'h79, 8);
    chk("t5_rvalid", valid, 4'b0001);
    chk("t5_rtmo", tmo, 1'b0);
    chk("t5_rdig", {d3, d2, d1, d0}, 16'h4321);

    // 3: unstable segments, then illegal select
    e0 = n_err;
    drive(4'b1110, 7'h12, 3);
    drive(4'b1110, 7'h02, 3);
    drive(4'b1110, 7'h78, 3);
    drive(4'b1110, 7'h12, 3);
    drive(4'b1110, 7'h02, 3);
    chk("t3_unstab", d0, 4'h1);
    drive(4'b1100, 7'h40, 20);
    chk("t3_multi", {d3, d2, d1, d0}, 16'h4321);
    chk("t3_valid", valid, 4'b0001);
    chk("t3_noerr", n_err - e0, 0);

    // 4: all-dark pattern on tens
    e0 = n_err;
    drive(4'b1101, 7'h7F, 8);
    chk("t4_err", n_err - e0, 1);
    chk("t4_ten", d1, 4'h2);
    chk("t4_valid", valid, 4'b0001);

    // 6: out-of-order scan 0,1,3,0,1,2,3
    f0 = n_frm;
    drive(4'b1110, 7'h12, 8);
    drive(4'b1101, 7'h02, 8);
    drive(4'b0111, 7'h78, 8);
    drive(4'b1110, 7'h00, 8);
    drive(4'b1101, 7'h10, 8);
    drive(4'b1011, 7'h08, 8);
    drive(4'b0111, 7'h03, 8);
    chk("t6_frame", n_frm - f0, 1);
    chk("t6_digits", {d3, d2, d1, d0}, 16'hBA98);
    chk("t6_valid", valid, 4'b1111);

    drive(4'b1110, 7'h79, 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst", {d3, d2, d1, d0, valid, frame, err, tmo}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 7'h7F, 4);
    chk("t6_post", {d3, d2, d1, d0, valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
